// File: rtl/iobuf_halfduplex_pkg.sv
// rtl/iobuf_halfduplex_pkg.sv - shared state encoding and defaults for the half-duplex pad sequencer
package iobuf_halfduplex_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TA_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TA_IN  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_TA_OUT = 3'd3,
    ST_SAMPLE = 3'd4
  } state_t;

endpackage

// File: rtl/iobuf_halfduplex_bit_timer.sv
// rtl/iobuf_halfduplex_bit_timer.sv - bit-period counter, flags the last and the middle cycle of each bit
module iobuf_halfduplex_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end,
  output logic             mid_bit
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // The counter is parked at 0 outside DRIVE/SAMPLE so each bit starts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= div;
      cnt   <= '0;
    end else if (run) begin
      cnt <= bit_end ? '0 : cnt + DIV_W'(1);
    end
  end

  assign bit_end = (cnt == div_q);
  assign mid_bit = (cnt == (div_q >> 1));

endmodule

// File: rtl/iobuf_halfduplex_seq.sv
// rtl/iobuf_halfduplex_seq.sv - half-duplex serial write/read sequencer for a tri-state pad buffer
module iobuf_halfduplex_seq
  import iobuf_halfduplex_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = 8,
  parameter int TA_CYC = DEF_TA_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rnw,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DIV_W-1:0]  div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              pad_i,
  output logic              pad_t,
  input  logic              pad_o
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int TA_W  = $clog2(TA_CYC + 1);

  state_t            state;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] rshift_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [TA_W-1:0]   ta_cnt;
  logic              load;
  logic              run;
  logic              bit_end;
  logic              mid_bit;
  logic              last_bit;
  logic              ta_last;

  assign load     = (state == ST_IDLE) && start;
  assign run      = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));
  assign ta_last  = (ta_cnt == TA_W'(TA_CYC - 1));
  // With DIV=0 the sample point and the bit end coincide, so the final word must include this cycle's pad_o.
  assign rshift_nxt = mid_bit ? {rshift[DATA_W-2:0], pad_o} : rshift;

  iobuf_halfduplex_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .run     (run),
    .div     (div),
    .bit_end (bit_end),
    .mid_bit (mid_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wshift  <= '0;
      rshift  <= '0;
      bit_idx <= '0;
      ta_cnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      pad_i   <= 1'b0;
      pad_t   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wshift  <= wdata;
            bit_idx <= '0;
            ta_cnt  <= '0;
            busy    <= 1'b1;
            state   <= rnw ? ST_SAMPLE : ST_TA_IN;
          end
        end
        ST_TA_IN: begin
          if (ta_last) begin
            state <= ST_DRIVE;
            pad_t <= 1'b0;
            pad_i <= wshift[DATA_W-1];
          end else begin
            ta_cnt <= ta_cnt + TA_W'(1);
          end
        end
        ST_DRIVE: begin
          if (bit_end) begin
            if (last_bit) begin
              state  <= ST_TA_OUT;
              pad_t  <= 1'b1;
              pad_i  <= 1'b0;
              ta_cnt <= '0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              wshift  <= {wshift[DATA_W-2:0], 1'b0};
              pad_i   <= wshift[DATA_W-2];
            end
          end
        end
        ST_TA_OUT: begin
          if (ta_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ta_cnt <= ta_cnt + TA_W'(1);
          end
        end
        ST_SAMPLE: begin
          rshift <= rshift_nxt;
          if (bit_end) begin
            if (last_bit) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              rdata <= rshift_nxt;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          pad_t <= 1'b1;
          pad_i <= 1'b0;
        end
      endcase
    end
  end

endmodule
